vga_block_motion_ctrl: RTL and testbench



---
 rtl/vga_block_motion_ctrl_if.sv | 30 +++
 rtl/vga_block_motion_ctrl.sv | 166 ++++++++++++++++
 tb/tb_vga_block_motion_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vga_block_motion_ctrl_if.sv
// Signal bundle between the VGA timing/pixel path and the block motion controller.
// The master side drives sync, enable, speed and pixel coordinates; the slave returns block state.
interface vga_block_motion_ctrl_if;
  logic        i_vga_vs;
  logic        i_en;
  logic [3:0]  i_speed;
  logic [9:0]  i_pix_x;
  logic [9:0]  i_pix_y;
  logic [9:0]  o_blk_x;
  logic [9:0]  o_blk_y;
  logic        o_dir_x;
  logic        o_dir_y;
  logic        o_pos_valid;
  logic        o_bounce_x;
  logic        o_bounce_y;
  logic        o_in_block;
  logic [15:0] o_frame_cnt;

  modport master (
    output i_vga_vs, i_en, i_speed, i_pix_x, i_pix_y,
    input  o_blk_x, o_blk_y, o_dir_x, o_dir_y, o_pos_valid,
           o_bounce_x, o_bounce_y, o_in_block, o_frame_cnt
  );

  modport slave (
    input  i_vga_vs, i_en, i_speed, i_pix_x, i_pix_y,
    output o_blk_x, o_blk_y, o_dir_x, o_dir_y, o_pos_valid,
           o_bounce_x, o_bounce_y, o_in_block, o_frame_cnt
  );
endinterface

// File: rtl/vga_block_motion_ctrl.sv
// Frame-synchronous bouncing-block position sequencer for the VGA pixel path.
// Steps X then Y once per VS falling edge and flags pixels inside the block.
module vga_block_motion_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BLK_W    = 64,
  parameter int BLK_H    = 64
) (
  input logic clk,
  input logic rst_n,
  vga_block_motion_ctrl_if.slave bus
);

  localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BLK_W);
  localparam logic [10:0] YMAX   = 11'(V_ACTIVE - BLK_H);
  localparam logic [9:0]  XMAX10 = 10'(H_ACTIVE - BLK_W);
  localparam logic [9:0]  YMAX10 = 10'(V_ACTIVE - BLK_H);
  localparam logic [9:0]  X_INIT = 10'((H_ACTIVE - BLK_W) / 2);
  localparam logic [9:0]  Y_INIT = 10'((V_ACTIVE - BLK_H) / 2);
  localparam logic [10:0] BW11   = 11'(BLK_W);
  localparam logic [10:0] BH11   = 11'(BLK_H);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MOVE_X, S_MOVE_Y} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vs_d;
  logic [3:0]  r_spd;
  logic [9:0]  r_blk_x;
  logic [9:0]  r_blk_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic        r_pos_valid;
  logic        r_bounce_x;
  logic        r_bounce_y;
  logic        r_in_block;
  logic [15:0] r_frame_cnt;

  logic        w_frame_edge;
  logic [10:0] w_spd11;
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;
  logic        w_x_left_hit;
  logic        w_y_left_hit;
  logic [9:0]  w_x_diff;
  logic [9:0]  w_y_diff;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_in_block;

  assign w_frame_edge = r_vs_d & ~bus.i_vga_vs;

  // All position arithmetic is done 11 bits wide so the sums cannot wrap.
  assign w_spd11      = {7'd0, r_spd};
  assign w_x_sum      = {1'b0, r_blk_x} + w_spd11;
  assign w_y_sum      = {1'b0, r_blk_y} + w_spd11;
  assign w_x_left_hit = ({1'b0, r_blk_x} <= w_spd11);
  assign w_y_left_hit = ({1'b0, r_blk_y} <= w_spd11);
  assign w_x_diff     = r_blk_x - {6'd0, r_spd};
  assign w_y_diff     = r_blk_y - {6'd0, r_spd};

  assign w_px       = {1'b0, bus.i_pix_x};
  assign w_py       = {1'b0, bus.i_pix_y};
  assign w_bx       = {1'b0, r_blk_x};
  assign w_by       = {1'b0, r_blk_y};
  assign w_in_block = (w_px >= w_bx) && (w_px < (w_bx + BW11)) &&
                      (w_py >= w_by) && (w_py < (w_by + BH11));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A frame edge is only honoured while waiting; edges during a move are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.i_en) w_next = S_WAIT;
      S_WAIT:   begin
        if (!bus.i_en)        w_next = S_IDLE;
        else if (w_frame_edge) w_next = S_MOVE_X;
      end
      S_MOVE_X: w_next = S_MOVE_Y;
      S_MOVE_Y: w_next = bus.i_en ? S_WAIT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d      <= 1'b1;
      r_spd       <= 4'd0;
      r_blk_x     <= X_INIT;
      r_blk_y     <= Y_INIT;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_pos_valid <= 1'b0;
      r_bounce_x  <= 1'b0;
      r_bounce_y  <= 1'b0;
      r_in_block  <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_vs_d      <= bus.i_vga_vs;
      r_pos_valid <= 1'b0;
      r_bounce_x  <= 1'b0;
      r_bounce_y  <= 1'b0;
      r_in_block  <= w_in_block;
      if (w_frame_edge) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_state == S_WAIT && bus.i_en && w_frame_edge) r_spd <= bus.i_speed;

      if (r_state == S_MOVE_X) begin
        if (r_dir_x) begin
          if (w_x_sum >= XMAX) begin
            r_blk_x    <= XMAX10;
            r_dir_x    <= 1'b0;
            r_bounce_x <= 1'b1;
          end else begin
            r_blk_x <= w_x_sum[9:0];
          end
        end else begin
          if (w_x_left_hit) begin
            r_blk_x    <= 10'd0;
            r_dir_x    <= 1'b1;
            r_bounce_x <= 1'b1;
          end else begin
            r_blk_x <= w_x_diff;
          end
        end
      end

      if (r_state == S_MOVE_Y) begin
        r_pos_valid <= 1'b1;
        if (r_dir_y) begin
          if (w_y_sum >= YMAX) begin
            r_blk_y    <= YMAX10;
            r_dir_y    <= 1'b0;
            r_bounce_y <= 1'b1;
          end else begin
            r_blk_y <= w_y_sum[9:0];
          end
        end else begin
          if (w_y_left_hit) begin
            r_blk_y    <= 10'd0;
            r_dir_y    <= 1'b1;
            r_bounce_y <= 1'b1;
          end else begin
            r_blk_y <= w_y_diff;
          end
        end
      end
    end
  end

  assign bus.o_blk_x     = r_blk_x;
  assign bus.o_blk_y     = r_blk_y;
  assign bus.o_dir_x     = r_dir_x;
  assign bus.o_dir_y     = r_dir_y;
  assign bus.o_pos_valid = r_pos_valid;
  assign bus.o_bounce_x  = r_bounce_x;
  assign bus.o_bounce_y  = r_bounce_y;
  assign bus.o_in_block  = r_in_block;
  assign bus.o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_block_motion_ctrl.sv
// Randomised self-checking bench for vga_block_motion_ctrl against a frame-level
// model of the bouncing block (position, direction, pulses, frame count, hit test).
module tb_vga_block_motion_ctrl;

  localparam int XMAX = 640 - 64;
  localparam int YMAX = 480 - 64;

  logic clk;
  logic rst_n;
  vga_block_motion_ctrl_if bus ();

  vga_block_motion_ctrl #(
    .H_ACTIVE(640), .V_ACTIVE(480), .BLK_W(64), .BLK_H(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  int mx, my, mcnt;
  bit mdx, mdy;

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One axis step exactly as the bounce rules read: clamp at the edge and flip.
  task automatic stepAxis(inout int p, inout bit d, input int s, input int maxv, output bit b);
    b = 1'b0;
    if (d) begin
      if (p + s >= maxv) begin p = maxv; d = 1'b0; b = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1'b1; b = 1'b1; end
      else p = p - s;
    end
  endtask

  task automatic modelReset();
    mx = 288; my = 208; mdx = 1'b1; mdy = 1'b1; mcnt = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_vga_vs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Drives one VS falling edge and checks the per-cycle response of the frame.
  task automatic applyStimulus(input int spd, input int newSpd, input bit dropEn);
    int oldX, oldY;
    bit moving, bx, by;
    bus.i_speed = 4'(spd);
    @(negedge clk);
    bus.i_vga_vs = 1'b0;
    moving = bus.i_en;
    oldX = mx; oldY = my;
    mcnt = (mcnt + 1) & 16'hFFFF;
    bx = 1'b0; by = 1'b0;
    if (moving) begin
      stepAxis(mx, mdx, spd, XMAX, bx);
      stepAxis(my, mdy, spd, YMAX, by);
    end
    @(negedge clk);
    bus.i_vga_vs = 1'b1;
    bus.i_speed = 4'(newSpd);
    if (dropEn) bus.i_en = 1'b0;
    checkOutput("x_before_move", int'(bus.o_blk_x), oldX);
    checkOutput("pv_edge1", int'(bus.o_pos_valid), 0);
    @(negedge clk);
    checkOutput("x_move", int'(bus.o_blk_x), mx);
    checkOutput("dir_x", int'(bus.o_dir_x), int'(mdx));
    checkOutput("bounce_x", int'(bus.o_bounce_x), int'(bx));
    checkOutput("y_before_move", int'(bus.o_blk_y), oldY);
    checkOutput("pv_edge2", int'(bus.o_pos_valid), 0);
    @(negedge clk);
    checkOutput("y_move", int'(bus.o_blk_y), my);
    checkOutput("dir_y", int'(bus.o_dir_y), int'(mdy));
    checkOutput("bounce_y", int'(bus.o_bounce_y), int'(by));
    checkOutput("bounce_x_clear", int'(bus.o_bounce_x), 0);
    checkOutput("pos_valid", int'(bus.o_pos_valid), int'(moving));
    @(negedge clk);
    checkOutput("pv_clear", int'(bus.o_pos_valid), 0);
    checkOutput("bounce_y_clear", int'(bus.o_bounce_y), 0);
    checkOutput("frame_cnt", int'(bus.o_frame_cnt), mcnt);
    @(negedge clk);
  endtask

  task automatic checkPixel(input int px, input int py);
    int exp;
    @(negedge clk);
    bus.i_pix_x = 10'(px);
    bus.i_pix_y = 10'(py);
    exp = (px >= mx && px < mx + 64 && py >= my && py < my + 64) ? 1 : 0;
    @(negedge clk);
    checkOutput("in_block", int'(bus.o_in_block), exp);
  endtask

  int px, py;

  initial begin
    rst_n = 1'b0;
    bus.i_vga_vs = 1'b1;
    bus.i_en = 1'b0;
    bus.i_speed = 4'd0;
    bus.i_pix_x = 10'd0;
    bus.i_pix_y = 10'd0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_blk_x", int'(bus.o_blk_x), 288);
    checkOutput("rst_blk_y", int'(bus.o_blk_y), 208);
    checkOutput("rst_dir_x", int'(bus.o_dir_x), 1);
    checkOutput("rst_dir_y", int'(bus.o_dir_y), 1);
    checkOutput("rst_pos_valid", int'(bus.o_pos_valid), 0);
    checkOutput("rst_in_block", int'(bus.o_in_block), 0);
    checkOutput("rst_frame_cnt", int'(bus.o_frame_cnt), 0);
    rst_n = 1'b1;

    $display("[TB] disabled frames");
    repeat (3) applyStimulus(int'($urandom_range(1, 15)), 3, 1'b0);
    checkOutput("idle_frames_cnt", int'(bus.o_frame_cnt), 3);
    checkOutput("idle_frames_x", int'(bus.o_blk_x), 288);

    $display("[TB] single step speed 2");
    bus.i_en = 1'b1;
    applyStimulus(2, 9, 1'b0);
    checkOutput("step2_x", int'(bus.o_blk_x), 290);
    checkOutput("step2_y", int'(bus.o_blk_y), 210);

    $display("[TB] speed 15 run from reset");
    doReset();
    repeat (20) applyStimulus(15, int'($urandom_range(0, 15)), 1'b0);
    checkOutput("run15_x", int'(bus.o_blk_x), 576);
    checkOutput("run15_dir_x", int'(bus.o_dir_x), 0);
    checkOutput("run15_y", int'(bus.o_blk_y), 326);
    repeat (40) applyStimulus(15, 15, 1'b0);

    $display("[TB] enable dropped mid-move");
    applyStimulus(5, 7, 1'b1);
    applyStimulus(5, 7, 1'b0);
    bus.i_en = 1'b1;
    applyStimulus(3, 3, 1'b0);

    $display("[TB] reset during a move");
    @(negedge clk);
    bus.i_vga_vs = 1'b0;
    @(negedge clk);
    bus.i_vga_vs = 1'b1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_x", int'(bus.o_blk_x), 288);
    checkOutput("mid_rst_cnt", int'(bus.o_frame_cnt), 0);
    @(negedge clk);
    checkOutput("mid_rst_pv", int'(bus.o_pos_valid), 0);
    checkOutput("mid_rst_bx", int'(bus.o_bounce_x), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_y", int'(bus.o_blk_y), 208);

    $display("[TB] in-block corners");
    checkPixel(288, 208);
    checkPixel(352, 208);
    checkPixel(351, 271);
    checkPixel(287, 240);
    checkPixel(300, 272);

    $display("[TB] randomised frames");
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) bus.i_en = ~bus.i_en;
      applyStimulus(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
      for (int k = 0; k < 2; k++) begin
        px = mx + int'($urandom_range(0, 80)) - 8;
        py = my + int'($urandom_range(0, 80)) - 8;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        checkPixel(px, py);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
